// File: rtl/pll_dyn_cfg_ctrl_pkg.sv
// Shared widths, FSM states and state-class helpers for the PLL dynamic-config controller.
package pll_dyn_cfg_ctrl_pkg;

  localparam int unsigned DIV_W  = 10;
  localparam int unsigned PH_W   = 13;
  localparam int unsigned LOSS_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWD       = 3'd1,
    ST_RST       = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_ERR       = 3'd5
  } state_t;

  // States in which a new configuration may be offered.
  function automatic logic state_accepts(input state_t s);
    return s inside {ST_IDLE, ST_LOCKED, ST_ERR};
  endfunction

  // States that belong to an active power-down/reset/lock sequence.
  function automatic logic state_busy(input state_t s);
    return s inside {ST_PWD, ST_RST, ST_WAIT_LOCK};
  endfunction

  // States in which the PLL is held in reset.
  function automatic logic state_holds_rst(input state_t s);
    return s inside {ST_IDLE, ST_PWD, ST_RST, ST_ERR};
  endfunction

endpackage

// File: rtl/pll_dyn_cfg_ctrl_if.sv
// Configuration handshake bus between system control logic and the PLL controller.
interface pll_dyn_cfg_ctrl_if
  import pll_dyn_cfg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH = 5
);

  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [DIV_W-1:0]         cfg_idiv;
  logic [DIV_W-1:0]         cfg_fdiv;
  logic [NUM_CH*DIV_W-1:0]  cfg_odiv;
  logic [NUM_CH*DIV_W-1:0]  cfg_duty;
  logic [NUM_CH*PH_W-1:0]   cfg_phase;

  modport master (
    output cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv, cfg_duty, cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv, cfg_duty, cfg_phase,
    output cfg_ready
  );

endinterface

// File: rtl/pll_dyn_cfg_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module pll_dyn_cfg_ctrl_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops; both clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// Initiator of the PLL dynamic-configuration sequence: accepts a config,
// powers down and resets the PLL, qualifies lock and relocks on lock loss.
module pll_dyn_cfg_ctrl
  import pll_dyn_cfg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH       = 5,
  parameter int unsigned PWD_CYCLES   = 10,
  parameter int unsigned RST_CYCLES   = 10,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned DEF_ODIV     = 100,
  parameter int unsigned DEF_DUTY     = 100,
  parameter int unsigned DEF_PHASE    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  pll_dyn_cfg_ctrl_if.slave        cfg,
  input  logic                     pll_lock,
  output logic                     pll_pwd,
  output logic                     pll_rst,
  output logic [DIV_W-1:0]         dyn_idiv,
  output logic [DIV_W-1:0]         dyn_fdiv,
  output logic [NUM_CH*DIV_W-1:0]  dyn_odiv,
  output logic [NUM_CH*DIV_W-1:0]  dyn_duty,
  output logic [NUM_CH*PH_W-1:0]   dyn_phase,
  output logic                     locked,
  output logic                     busy,
  output logic                     done,
  output logic                     err_param,
  output logic                     err_timeout,
  output logic                     err_lost,
  output logic [LOSS_W-1:0]        loss_cnt
);

  localparam int unsigned SEQ_MAX = (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > SEQ_MAX) ? LOCK_TIMEOUT : SEQ_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned STB_W   = $clog2(LOCK_STABLE + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [STB_W-1:0]   stable, stable_next;
  logic               lock_s;
  logic               cfg_ok, xfer, accept, loss;

  logic               pll_pwd_d, pll_rst_d, ready_d, busy_d, locked_d, done_d;
  logic               err_param_d, err_timeout_d, err_lost_d;
  logic [LOSS_W-1:0]  loss_cnt_d;

  pll_dyn_cfg_ctrl_sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // A config is usable only if no divider is zero.
  always_comb begin
    cfg_ok = (cfg.cfg_idiv != '0) && (cfg.cfg_fdiv != '0);
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (cfg.cfg_odiv[i*DIV_W +: DIV_W] == '0) cfg_ok = 1'b0;
    end
  end

  assign xfer   = cfg.cfg_valid && cfg.cfg_ready;
  assign accept = xfer && cfg_ok;
  // A simultaneous accepted config takes priority over a lock loss.
  assign loss   = (state == ST_LOCKED) && !lock_s && !accept;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state plus the shared phase/timeout counter and lock-stability counter.
  always_comb begin
    state_next  = state;
    cnt_next    = '0;
    stable_next = '0;
    case (state)
      ST_IDLE, ST_ERR: if (accept) state_next = ST_PWD;
      ST_PWD:          if (cnt == CNT_W'(PWD_CYCLES - 1)) state_next = ST_RST;
      ST_RST:          if (cnt == CNT_W'(RST_CYCLES - 1)) state_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s && (stable == STB_W'(LOCK_STABLE - 1))) state_next = ST_LOCKED;
        else if (cnt == CNT_W'(LOCK_TIMEOUT - 1))           state_next = ST_ERR;
      end
      ST_LOCKED: begin
        if (accept)    state_next = ST_PWD;
        else if (loss) state_next = ST_RST;
      end
      default:         state_next = ST_IDLE;
    endcase
    if ((state_next == state) && state_busy(state)) cnt_next = cnt + CNT_W'(1);
    if ((state == ST_WAIT_LOCK) && (state_next == ST_WAIT_LOCK) && lock_s)
      stable_next = stable + STB_W'(1);
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    pll_pwd_d     = (state_next == ST_PWD);
    pll_rst_d     = state_holds_rst(state_next);
    ready_d       = state_accepts(state_next);
    busy_d        = state_busy(state_next);
    locked_d      = (state_next == ST_LOCKED);
    done_d        = (state_next == ST_LOCKED) && (state != ST_LOCKED);
    err_param_d   = xfer && !cfg_ok;
    err_timeout_d = err_timeout;
    err_lost_d    = err_lost;
    loss_cnt_d    = loss_cnt;
    if (accept) begin
      err_timeout_d = 1'b0;
      err_lost_d    = 1'b0;
      loss_cnt_d    = '0;
    end else begin
      if ((state == ST_WAIT_LOCK) && (state_next == ST_ERR)) err_timeout_d = 1'b1;
      if (loss) begin
        err_lost_d = 1'b1;
        if (loss_cnt != '1) loss_cnt_d = loss_cnt + LOSS_W'(1);
      end
    end
  end

  // Counters, registered outputs and the config registers driven to the PLL.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      stable        <= '0;
      pll_pwd       <= 1'b0;
      pll_rst       <= 1'b1;
      cfg.cfg_ready <= 1'b1;
      busy          <= 1'b0;
      locked        <= 1'b0;
      done          <= 1'b0;
      err_param     <= 1'b0;
      err_timeout   <= 1'b0;
      err_lost      <= 1'b0;
      loss_cnt      <= '0;
      dyn_idiv      <= DIV_W'(2);
      dyn_fdiv      <= DIV_W'(32);
      dyn_odiv      <= {NUM_CH{DIV_W'(DEF_ODIV)}};
      dyn_duty      <= {NUM_CH{DIV_W'(DEF_DUTY)}};
      dyn_phase     <= {NUM_CH{PH_W'(DEF_PHASE)}};
    end else begin
      cnt           <= cnt_next;
      stable        <= stable_next;
      pll_pwd       <= pll_pwd_d;
      pll_rst       <= pll_rst_d;
      cfg.cfg_ready <= ready_d;
      busy          <= busy_d;
      locked        <= locked_d;
      done          <= done_d;
      err_param     <= err_param_d;
      err_timeout   <= err_timeout_d;
      err_lost      <= err_lost_d;
      loss_cnt      <= loss_cnt_d;
      if (accept) begin
        dyn_idiv  <= cfg.cfg_idiv;
        dyn_fdiv  <= cfg.cfg_fdiv;
        dyn_odiv  <= cfg.cfg_odiv;
        dyn_duty  <= cfg.cfg_duty;
        dyn_phase <= cfg.cfg_phase;
      end
    end
  end

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Bench for pll_dyn_cfg_ctrl: phase/countdown reference model, per-cycle compare
// and directed scenarios with hand-computed timing expectations.
module tb_pll_dyn_cfg_ctrl;
  import pll_dyn_cfg_ctrl_pkg::*;

  localparam int unsigned NUM_CH       = 5;
  localparam int unsigned PWD_CYCLES   = 10;
  localparam int unsigned RST_CYCLES   = 10;
  localparam int unsigned LOCK_STABLE  = 16;
  localparam int unsigned LOCK_TIMEOUT = 1000;
  localparam int          LOCK_DELAY   = 200;
  localparam int unsigned OW           = NUM_CH * DIV_W;
  localparam int unsigned PW           = NUM_CH * PH_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_lock = 1'b0;
  logic pll_pwd, pll_rst, locked, busy, done, err_param, err_timeout, err_lost;
  logic [DIV_W-1:0] dyn_idiv, dyn_fdiv;
  logic [OW-1:0]    dyn_odiv, dyn_duty;
  logic [PW-1:0]    dyn_phase;
  logic [7:0]       loss_cnt;

  bit lock_en   = 1'b1;
  bit lock_kill = 1'b0;
  bit chk_en    = 1'b0;
  int cyc       = 0;
  int n_chk     = 0;
  int n_err     = 0;

  pll_dyn_cfg_ctrl_if #(.NUM_CH(NUM_CH)) cfg_if ();

  pll_dyn_cfg_ctrl #(
    .NUM_CH(NUM_CH), .PWD_CYCLES(PWD_CYCLES), .RST_CYCLES(RST_CYCLES),
    .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .DEF_ODIV(100), .DEF_DUTY(100), .DEF_PHASE(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg(cfg_if), .pll_lock(pll_lock),
    .pll_pwd(pll_pwd), .pll_rst(pll_rst),
    .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv), .dyn_odiv(dyn_odiv),
    .dyn_duty(dyn_duty), .dyn_phase(dyn_phase),
    .locked(locked), .busy(busy), .done(done), .err_param(err_param),
    .err_timeout(err_timeout), .err_lost(err_lost), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PLL stand-in: lock rises LOCK_DELAY cycles after its reset falls.
  int lk_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (pll_rst === 1'b1) lk_cnt = 0;
    else                  lk_cnt++;
    pll_lock = lock_en && !lock_kill && (lk_cnt > LOCK_DELAY);
  end

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_POWERDOWN, P_RESET, P_ACQUIRE, P_LOCKED, P_FAULT} phase_e;
  phase_e m_ph = P_IDLE;
  int m_left, m_run, m_loss;
  bit m_done, m_eparam, m_etime, m_elost;
  logic [DIV_W-1:0] m_idiv, m_fdiv;
  logic [OW-1:0]    m_odiv, m_duty;
  logic [PW-1:0]    m_phase;
  bit hist[$];

  function automatic bit ready_of(input phase_e p);
    return (p == P_IDLE) || (p == P_LOCKED) || (p == P_FAULT);
  endfunction

  function automatic bit cfg_acceptable();
    if (cfg_if.cfg_idiv == 0 || cfg_if.cfg_fdiv == 0) return 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++)
      if (cfg_if.cfg_odiv[i*DIV_W +: DIV_W] == 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : ref_model
    bit ls, offered, good;
    if (rst) begin
      m_ph = P_IDLE; m_left = 0; m_run = 0; m_loss = 0;
      m_done = 0; m_eparam = 0; m_etime = 0; m_elost = 0;
      m_idiv = 10'd2; m_fdiv = 10'd32;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        m_odiv[i*DIV_W +: DIV_W] = 10'd100;
        m_duty[i*DIV_W +: DIV_W] = 10'd100;
        m_phase[i*PH_W +: PH_W]  = 13'd16;
      end
      hist.delete();
    end else begin
      // Synchronized lock seen now is the raw lock from two edges ago.
      ls = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      hist.push_back(pll_lock === 1'b1);
      if (hist.size() > 2) void'(hist.pop_front());
      offered  = (cfg_if.cfg_valid === 1'b1) && ready_of(m_ph);
      good     = cfg_acceptable();
      m_done   = 0;
      m_eparam = offered && !good;
      if (offered && good) begin
        m_idiv = cfg_if.cfg_idiv; m_fdiv = cfg_if.cfg_fdiv;
        m_odiv = cfg_if.cfg_odiv; m_duty = cfg_if.cfg_duty; m_phase = cfg_if.cfg_phase;
        m_etime = 0; m_elost = 0; m_loss = 0;
        m_ph = P_POWERDOWN; m_left = PWD_CYCLES;
      end else begin
        case (m_ph)
          P_POWERDOWN: begin
            m_left--;
            if (m_left == 0) begin m_ph = P_RESET; m_left = RST_CYCLES; end
          end
          P_RESET: begin
            m_left--;
            if (m_left == 0) begin m_ph = P_ACQUIRE; m_left = LOCK_TIMEOUT; m_run = 0; end
          end
          P_ACQUIRE: begin
            m_run = ls ? m_run + 1 : 0;
            m_left--;
            if (m_run == int'(LOCK_STABLE)) begin m_ph = P_LOCKED; m_done = 1; end
            else if (m_left == 0)          begin m_ph = P_FAULT; m_etime = 1; end
          end
          P_LOCKED: begin
            if (!ls) begin
              m_elost = 1;
              if (m_loss < 255) m_loss++;
              m_ph = P_RESET; m_left = RST_CYCLES;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("status",
            {pll_pwd, pll_rst, cfg_if.cfg_ready, busy, locked, done,
             err_param, err_timeout, err_lost, loss_cnt},
            {m_ph == P_POWERDOWN,
             (m_ph == P_IDLE) || (m_ph == P_POWERDOWN) || (m_ph == P_RESET) || (m_ph == P_FAULT),
             ready_of(m_ph),
             (m_ph == P_POWERDOWN) || (m_ph == P_RESET) || (m_ph == P_ACQUIRE),
             m_ph == P_LOCKED, m_done, m_eparam, m_etime, m_elost, 8'(m_loss)});
      check("dyn_bus", {dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase},
            {m_idiv, m_fdiv, m_odiv, m_duty, m_phase});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send_cfg(input int idiv, input int fdiv, input int odiv,
                          input int duty, input int phase);
    cfg_if.cfg_idiv = DIV_W'(idiv);
    cfg_if.cfg_fdiv = DIV_W'(fdiv);
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cfg_if.cfg_odiv[i*DIV_W +: DIV_W] = DIV_W'(odiv);
      cfg_if.cfg_duty[i*DIV_W +: DIV_W] = DIV_W'(duty);
      cfg_if.cfg_phase[i*PH_W +: PH_W]  = PH_W'(phase);
    end
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int n_pwd, output int n_rst,
                                output int fall_at, output int done_at, output bit saw_rst);
    bit prev_rst = 1'b1;
    n_pwd = 0; n_rst = 0; fall_at = -1; done_at = -1; saw_rst = 0;
    for (int i = 0; i < budget; i++) begin
      if (pll_pwd) n_pwd++;
      if (pll_rst && !pll_pwd) n_rst++;
      if (pll_rst) saw_rst = 1;
      if (!pll_rst && prev_rst && fall_at < 0) fall_at = cyc;
      prev_rst = pll_rst;
      if (done) begin done_at = cyc; break; end
      tick();
    end
    check("done_within_budget", done_at >= 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_pwd, n_rst, fall_at, done_at, err_at;
    bit saw_rst, prev;
    logic [OW-1:0] exp_o;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_idiv  = '0;
    cfg_if.cfg_fdiv  = '0;
    cfg_if.cfg_odiv  = '0;
    cfg_if.cfg_duty  = '0;
    cfg_if.cfg_phase = '0;
    rst = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Idle after reset: PLL held in reset, defaults on the buses.
    repeat (50) tick();
    check("idle_pll_rst", pll_rst, 1);
    check("idle_pll_pwd", pll_pwd, 0);
    check("idle_odiv0", dyn_odiv[DIV_W-1:0], 100);
    check("idle_ready", cfg_if.cfg_ready, 1);
    check("idle_busy", busy, 0);

    // First config: sequence lengths and lock latency.
    send_cfg(4, 40, 100, 100, 16);
    run_until_done(400, n_pwd, n_rst, fall_at, done_at, saw_rst);
    check("seq_pwd_len", n_pwd, 10);
    check("seq_rst_len", n_rst, 10);
    check("lock_latency", done_at - fall_at, 218);
    check("locked_after_done", locked, 1);

    // Reconfigure from LOCKED.
    send_cfg(4, 40, 200, 200, 16);
    for (int i = 0; i < int'(NUM_CH); i++) exp_o[i*DIV_W +: DIV_W] = 10'd200;
    check("reconf_odiv", dyn_odiv, exp_o);
    check("reconf_duty", dyn_duty, exp_o);
    run_until_done(400, n_pwd, n_rst, fall_at, done_at, saw_rst);
    check("reconf_latency", done_at - fall_at, 218);
    check("reconf_errs", {err_param, err_timeout, err_lost}, 0);

    // Two lock drops of 3 cycles each, each followed by an automatic relock.
    for (int k = 0; k < 2; k++) begin
      lock_kill = 1'b1;
      repeat (3) tick();
      lock_kill = 1'b0;
      run_until_done(400, n_pwd, n_rst, fall_at, done_at, saw_rst);
      check("loss_rst_pulse", saw_rst, 1);
    end
    check("loss_flag", err_lost, 1);
    check("loss_count", loss_cnt, 2);
    check("loss_relocked", locked, 1);

    // One-cycle lock glitch once ten stable cycles have been counted.
    send_cfg(4, 40, 100, 100, 16);
    fall_at = -1;
    for (int i = 0; i < 50; i++) begin
      if (!pll_rst) begin fall_at = cyc; break; end
      tick();
    end
    check("glitch_reach_wait", fall_at >= 0, 1);
    repeat (210) tick();
    lock_kill = 1'b1;
    tick();
    lock_kill = 1'b0;
    run_until_done(100, n_pwd, n_rst, err_at, done_at, saw_rst);
    check("glitch_latency", done_at - fall_at, 229);
    check("glitch_loss_cleared", {err_lost, loss_cnt}, 0);

    // Rejected config: only err_param reacts.
    send_cfg(4, 0, 100, 100, 16);
    check("param_pulse", err_param, 1);
    check("param_pll_rst", pll_rst, 0);
    check("param_locked", locked, 1);
    tick();
    check("param_pulse_end", err_param, 0);

    // PLL never locks: timeout into ERR.
    lock_en = 1'b0;
    send_cfg(4, 40, 100, 100, 16);
    fall_at = -1; err_at = -1; prev = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      if (!pll_rst && prev && fall_at < 0) fall_at = cyc;
      prev = pll_rst;
      if (err_timeout) begin err_at = cyc; break; end
      tick();
    end
    check("timeout_latency", err_at - fall_at, 1000);
    check("timeout_pll_rst", pll_rst, 1);
    check("timeout_ready", cfg_if.cfg_ready, 1);
    check("timeout_busy", busy, 0);

    // Reset asserted in the middle of RST.
    lock_en = 1'b1;
    send_cfg(3, 40, 50, 60, 7);
    repeat (13) tick();
    check("midrst_in_rst", {pll_pwd, pll_rst, busy}, 3'b011);
    rst = 1'b1;
    tick();
    check("midrst_pll_rst", pll_rst, 1);
    check("midrst_pll_pwd", pll_pwd, 0);
    check("midrst_divs", {dyn_idiv, dyn_fdiv, dyn_odiv[DIV_W-1:0]}, {10'd2, 10'd32, 10'd100});
    check("midrst_flags", {busy, cfg_if.cfg_ready, err_timeout}, 3'b010);
    rst = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
